// File: rtl/switch_allocator.sv
// Wormhole switch allocator for the 5-port mesh router (ports L, E, N, W, S).
// Each output is arbitrated round-robin among head flits, and it stays locked to
// the winning input until that input's tail flit transfers.
// The grant, out_valid and xbar_sel outputs are combinational. They depend only on
// the registered lock state, req_valid, out_ready and the owner's flit type.
// req_port feeds only the arbitration, so there is no path from req_port to grant.
module switch_allocator #(
   parameter int NUM_PORTS = 5,
   parameter int PORT_W    = 3
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_PORTS-1:0]        req_valid,
   input  logic [2*NUM_PORTS-1:0]      req_type,
   input  logic [PORT_W*NUM_PORTS-1:0] req_port,
   input  logic [NUM_PORTS-1:0]        out_ready,
   output logic [NUM_PORTS-1:0]        grant,
   output logic [NUM_PORTS-1:0]        out_valid,
   output logic [PORT_W*NUM_PORTS-1:0] xbar_sel
);

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_LOCKED = 1'b1
   } state_e;

   state_e            state_q [NUM_PORTS];
   state_e            state_d [NUM_PORTS];
   logic [PORT_W-1:0] owner_q [NUM_PORTS];
   logic [PORT_W-1:0] owner_d [NUM_PORTS];
   logic [PORT_W-1:0] ptr_q   [NUM_PORTS];
   logic [PORT_W-1:0] ptr_d   [NUM_PORTS];

   logic [NUM_PORTS-1:0] is_head;   // HDR (10) or single-flit (11)
   logic [NUM_PORTS-1:0] is_tail;   // TAIL (01) or single-flit (11)
   logic [NUM_PORTS-1:0] owns;      // input currently holds some output
   logic [NUM_PORTS-1:0] xfer;      // per output: flit moves this cycle
   logic [NUM_PORTS-1:0] cand [NUM_PORTS];
   logic [PORT_W:0]      pick [NUM_PORTS];

   // Round-robin pick. The MSB flags a winner and the low bits hold its index.
   // The scan runs backwards so that the last hit is the first input at or after ptr.
   function automatic logic [PORT_W:0] rr_pick(input logic [NUM_PORTS-1:0] c,
                                               input logic [PORT_W-1:0]    ptr);
      logic [PORT_W:0] res;
      int              idx;
      res = '0;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
         if (c[idx]) res = {1'b1, PORT_W'(idx)};
      end
      return res;
   endfunction

   // Successor of an input index, wrapping at NUM_PORTS.
   function automatic logic [PORT_W-1:0] next_idx(input logic [PORT_W-1:0] a);
      return (a == PORT_W'(NUM_PORTS - 1)) ? '0 : a + 1'b1;
   endfunction

   // Decode flit types and find which inputs already own an output.
   always_comb begin
      is_head = '0;
      is_tail = '0;
      owns    = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         is_head[i] = req_type[2*i+1];
         is_tail[i] = req_type[2*i];
      end
      for (int o = 0; o < NUM_PORTS; o++) begin
         if (state_q[o] == S_LOCKED) owns[owner_q[o]] = 1'b1;
      end
   end

   // Candidate matrix: a valid head on a non-owning input requesting this output.
   // Codes 0, 6 and 7 never match any output.
   always_comb begin
      for (int o = 0; o < NUM_PORTS; o++) begin
         cand[o] = '0;
         for (int i = 0; i < NUM_PORTS; i++) begin
            cand[o][i] = req_valid[i] & is_head[i] & ~owns[i] &
                         (req_port[i*PORT_W +: PORT_W] == PORT_W'(o + 1));
         end
      end
   end

   // Crossbar drive: a locked output forwards its owner's flit when downstream is ready.
   always_comb begin
      grant     = '0;
      out_valid = '0;
      xfer      = '0;
      xbar_sel  = '1;
      for (int o = 0; o < NUM_PORTS; o++) begin
         if (state_q[o] == S_LOCKED) begin
            out_valid[o] = req_valid[owner_q[o]];
            xfer[o]      = req_valid[owner_q[o]] & out_ready[o];
            if (xfer[o]) grant[owner_q[o]] = 1'b1;
            xbar_sel[o*PORT_W +: PORT_W] = owner_q[o];
         end
      end
   end

   // Per-output FSM next state.
   // IDLE allocates to the round-robin winner. LOCKED releases on the tail transfer.
   // A released output always spends one cycle in IDLE before it is reallocated.
   always_comb begin
      for (int o = 0; o < NUM_PORTS; o++) begin
         state_d[o] = state_q[o];
         owner_d[o] = owner_q[o];
         ptr_d[o]   = ptr_q[o];
         pick[o]    = rr_pick(cand[o], ptr_q[o]);
         if (state_q[o] == S_IDLE) begin
            if (pick[o][PORT_W]) begin
               state_d[o] = S_LOCKED;
               owner_d[o] = pick[o][PORT_W-1:0];
            end
         end else if (xfer[o] && is_tail[owner_q[o]]) begin
            state_d[o] = S_IDLE;
            ptr_d[o]   = next_idx(owner_q[o]);
         end
      end
   end

   // State registers. Reset abandons any packet in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int o = 0; o < NUM_PORTS; o++) begin
            state_q[o] <= S_IDLE;
            owner_q[o] <= '0;
            ptr_q[o]   <= '0;
         end
      end else begin
         for (int o = 0; o < NUM_PORTS; o++) begin
            state_q[o] <= state_d[o];
            owner_q[o] <= owner_d[o];
            ptr_q[o]   <= ptr_d[o];
         end
      end
   end

endmodule

// File: tb/tb_switch_allocator.sv
// Directed testbench for switch_allocator.
// Inputs are driven 1 time unit after each rising edge.
// Outputs are checked on the falling edge of the same cycle.
module tb_switch_allocator;

   localparam logic [1:0]  HDR  = 2'b10;
   localparam logic [1:0]  BODY = 2'b00;
   localparam logic [1:0]  TAIL = 2'b01;
   localparam logic [1:0]  SGL  = 2'b11;
   localparam logic [14:0] ALL7 = 15'h7fff;

   logic        clk;
   logic        rst_n;
   logic [4:0]  req_valid;
   logic [9:0]  req_type;
   logic [14:0] req_port;
   logic [4:0]  out_ready;
   logic [4:0]  grant;
   logic [4:0]  out_valid;
   logic [14:0] xbar_sel;

   int n_tests;
   int n_fail;

   switch_allocator #(.NUM_PORTS(5), .PORT_W(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_type  (req_type),
      .req_port  (req_port),
      .out_ready (out_ready),
      .grant     (grant),
      .out_valid (out_valid),
      .xbar_sel  (xbar_sel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tests++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
      end
   endtask

   // Expected xbar_sel with every output idle (7) except output o, which selects v.
   function automatic logic [14:0] xs(input int o, input int v);
      logic [14:0] r;
      r = ALL7;
      r[o*3 +: 3] = 3'(v);
      return r;
   endfunction

   task automatic drive(input int i, input logic v, input logic [1:0] t, input logic [2:0] p);
      req_valid[i]      = v;
      req_type[2*i +: 2] = t;
      req_port[3*i +: 3] = p;
   endtask

   // Check one cycle's outputs at the falling edge, then move to just after the next rising edge.
   task automatic exp_cyc(input string tag, input logic [4:0] g, input logic [4:0] ov,
                          input logic [14:0] x);
      @(negedge clk);
      check({tag, ".grant"}, 32'(grant), 32'(g));
      check({tag, ".ovld"},  32'(out_valid), 32'(ov));
      check({tag, ".xsel"},  32'(xbar_sel), 32'(x));
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      req_valid = '0;
      req_type  = '0;
      req_port  = '0;
      out_ready = '1;

      // Reset state, with a head flit present that must be ignored.
      drive(0, 1'b1, HDR, 3'd2);
      exp_cyc("rst", 5'b0, 5'b0, ALL7);
      drive(0, 1'b0, BODY, 3'd0);
      rst_n = 1'b1;
      exp_cyc("idle", 5'b0, 5'b0, ALL7);

      // 1: input 0 sends a 3-flit packet to E (output 1).
      drive(0, 1'b1, HDR, 3'd2);
      exp_cyc("t1.arb",  5'b00000, 5'b00000, ALL7);
      exp_cyc("t1.hdr",  5'b00001, 5'b00010, xs(1, 0));
      drive(0, 1'b1, BODY, 3'd2);
      exp_cyc("t1.body", 5'b00001, 5'b00010, xs(1, 0));
      drive(0, 1'b1, TAIL, 3'd2);
      exp_cyc("t1.tail", 5'b00001, 5'b00010, xs(1, 0));
      drive(0, 1'b0, BODY, 3'd0);
      exp_cyc("t1.rel",  5'b00000, 5'b00000, ALL7);

      // 2: inputs 0 and 3 contend for S (output 4). Input 0 wins, then input 3, then the pointer moves to 4.
      drive(0, 1'b1, HDR, 3'd5);
      drive(3, 1'b1, HDR, 3'd5);
      exp_cyc("t2.arb",  5'b00000, 5'b00000, ALL7);
      exp_cyc("t2.h0",   5'b00001, 5'b10000, xs(4, 0));
      drive(0, 1'b1, BODY, 3'd5);
      exp_cyc("t2.b0",   5'b00001, 5'b10000, xs(4, 0));
      drive(0, 1'b1, TAIL, 3'd5);
      exp_cyc("t2.t0",   5'b00001, 5'b10000, xs(4, 0));
      drive(0, 1'b0, BODY, 3'd0);
      exp_cyc("t2.arb3", 5'b00000, 5'b00000, ALL7);
      exp_cyc("t2.h3",   5'b01000, 5'b10000, xs(4, 3));
      drive(3, 1'b1, TAIL, 3'd5);
      exp_cyc("t2.t3",   5'b01000, 5'b10000, xs(4, 3));
      // The pointer is now 4, so input 4 beats input 0. After that it wraps to 0.
      drive(3, 1'b0, BODY, 3'd0);
      drive(0, 1'b1, HDR, 3'd5);
      drive(4, 1'b1, HDR, 3'd5);
      exp_cyc("t2.arb4", 5'b00000, 5'b00000, ALL7);
      exp_cyc("t2.h4",   5'b10000, 5'b10000, xs(4, 4));
      drive(4, 1'b1, TAIL, 3'd5);
      exp_cyc("t2.t4",   5'b10000, 5'b10000, xs(4, 4));
      drive(4, 1'b0, BODY, 3'd0);
      exp_cyc("t2.arb0", 5'b00000, 5'b00000, ALL7);
      exp_cyc("t2.h0b",  5'b00001, 5'b10000, xs(4, 0));
      drive(0, 1'b1, TAIL, 3'd5);
      exp_cyc("t2.t0b",  5'b00001, 5'b10000, xs(4, 0));
      drive(0, 1'b0, BODY, 3'd0);
      exp_cyc("t2.rel",  5'b00000, 5'b00000, ALL7);

      // 3: back-pressure on N (output 2) holds the lock for 4 cycles.
      drive(1, 1'b1, HDR, 3'd3);
      out_ready = 5'b11011;
      exp_cyc("t3.arb", 5'b00000, 5'b00000, ALL7);
      for (int k = 0; k < 4; k++) exp_cyc("t3.stall", 5'b00000, 5'b00100, xs(2, 1));
      out_ready = 5'b11111;
      exp_cyc("t3.hdr", 5'b00010, 5'b00100, xs(2, 1));
      drive(1, 1'b1, BODY, 3'd3);
      exp_cyc("t3.body", 5'b00010, 5'b00100, xs(2, 1));
      drive(1, 1'b1, TAIL, 3'd3);
      exp_cyc("t3.tail", 5'b00010, 5'b00100, xs(2, 1));
      drive(1, 1'b0, BODY, 3'd0);
      exp_cyc("t3.rel", 5'b00000, 5'b00000, ALL7);

      // 4: single-flit packets to W (output 3).
      drive(2, 1'b1, SGL, 3'd4);
      exp_cyc("t4.arb",  5'b00000, 5'b00000, ALL7);
      exp_cyc("t4.sgl",  5'b00100, 5'b01000, xs(3, 2));
      drive(2, 1'b0, BODY, 3'd0);
      exp_cyc("t4.idle", 5'b00000, 5'b00000, ALL7);
      // Pointer 3: input 1 first, then 2, then 1, with a bubble between grants.
      drive(1, 1'b1, SGL, 3'd4);
      drive(2, 1'b1, SGL, 3'd4);
      exp_cyc("t4.arbA", 5'b00000, 5'b00000, ALL7);
      exp_cyc("t4.g1",   5'b00010, 5'b01000, xs(3, 1));
      exp_cyc("t4.arbB", 5'b00000, 5'b00000, ALL7);
      exp_cyc("t4.g2",   5'b00100, 5'b01000, xs(3, 2));
      drive(2, 1'b0, BODY, 3'd0);
      exp_cyc("t4.arbC", 5'b00000, 5'b00000, ALL7);
      exp_cyc("t4.g1b",  5'b00010, 5'b01000, xs(3, 1));
      drive(1, 1'b0, BODY, 3'd0);
      exp_cyc("t4.rel",  5'b00000, 5'b00000, ALL7);

      // 5: input 4 with invalid codes 0 and 7 is never served, while input 1 goes to L normally.
      drive(4, 1'b1, HDR, 3'd0);
      drive(1, 1'b1, HDR, 3'd1);
      exp_cyc("t5.arb", 5'b00000, 5'b00000, ALL7);
      exp_cyc("t5.h1",  5'b00010, 5'b00001, xs(0, 1));
      drive(1, 1'b1, TAIL, 3'd1);
      exp_cyc("t5.t1",  5'b00010, 5'b00001, xs(0, 1));
      drive(1, 1'b0, BODY, 3'd0);
      for (int k = 0; k < 20; k++) begin
         if (k == 10) drive(4, 1'b1, HDR, 3'd7);
         exp_cyc("t5.bad", 5'b00000, 5'b00000, ALL7);
      end
      drive(4, 1'b0, BODY, 3'd0);

      // 6: reset after the head transfer abandons the packet. The stale BODY is not granted.
      drive(0, 1'b1, HDR, 3'd2);
      exp_cyc("t6.arb", 5'b00000, 5'b00000, ALL7);
      exp_cyc("t6.hdr", 5'b00001, 5'b00010, xs(1, 0));
      drive(0, 1'b1, BODY, 3'd2);
      rst_n = 1'b0;
      exp_cyc("t6.rst", 5'b00000, 5'b00000, ALL7);
      rst_n = 1'b1;
      exp_cyc("t6.body0", 5'b00000, 5'b00000, ALL7);
      exp_cyc("t6.body1", 5'b00000, 5'b00000, ALL7);
      drive(0, 1'b1, HDR, 3'd2);
      exp_cyc("t6.arb2", 5'b00000, 5'b00000, ALL7);
      exp_cyc("t6.hdr2", 5'b00001, 5'b00010, xs(1, 0));
      drive(0, 1'b1, TAIL, 3'd2);
      exp_cyc("t6.tail", 5'b00001, 5'b00010, xs(1, 0));
      drive(0, 1'b0, BODY, 3'd0);
      exp_cyc("t6.rel",  5'b00000, 5'b00000, ALL7);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
